// File: rtl/counter_sequence_checker.sv
// counter_sequence_checker: registers a 4-bit counter's q/qbar and checks +1 stepping and complements.
// Define COUNTER_SEQUENCE_CHECKER_HOLD_ALLOW_EN to accept a repeated (stalled) sample in TRACK.

module counter_sequence_checker #(
  parameter int ROLL_WIDTH    = 8,
  parameter int ERR_WIDTH     = 4,
  parameter bit STOP_ON_ERROR = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  q0,
  input  logic                  q1,
  input  logic                  q2,
  input  logic                  q3,
  input  logic                  qbar0,
  input  logic                  qbar1,
  input  logic                  qbar2,
  input  logic                  qbar3,
  output logic [3:0]            count_value,
  output logic                  rollover_pulse,
  output logic [ROLL_WIDTH-1:0] rollover_count,
  output logic                  error_flag,
  output logic [1:0]            error_cause,
  output logic [ERR_WIDTH-1:0]  error_count,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } state_e;

  localparam logic [ROLL_WIDTH-1:0] ROLL_ONE = 1;
  localparam logic [ERR_WIDTH-1:0]  ERR_ONE  = 1;

  state_e                state_q, state_d;
  logic [3:0]            last_q, last_d;
  logic [3:0]            cv_q, cv_d;
  logic                  pulse_q, pulse_d;
  logic [ROLL_WIDTH-1:0] roll_q, roll_d;
  logic                  eflag_q, eflag_d;
  logic [1:0]            ecause_q, ecause_d;
  logic [ERR_WIDTH-1:0]  ecnt_q, ecnt_d;

  logic [3:0] cur;
  logic [3:0] cur_from_bar;
  logic [3:0] exp_next;
  logic       hold;
  logic       seq_err;
  logic       comp_err;
  logic       wrap;

  always_comb begin
    cur          = {q3, q2, q1, q0};
    cur_from_bar = ~{qbar3, qbar2, qbar1, qbar0};
    exp_next     = last_q + 4'd1;
`ifdef COUNTER_SEQUENCE_CHECKER_HOLD_ALLOW_EN
    hold = (cur == last_q);
`else
    hold = 1'b0;
`endif
    comp_err = (cur != cur_from_bar);
    seq_err  = (cur != exp_next) && !hold;
    wrap     = (last_q == 4'hF) && (cur == 4'h0);
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cv_d     = enable ? cur : cv_q;
    pulse_d  = 1'b0;
    roll_d   = roll_q;
    eflag_d  = eflag_q;
    ecause_d = ecause_q;
    ecnt_d   = ecnt_q;
    if (clear) begin
      state_d  = IDLE;
      roll_d   = '0;
      eflag_d  = 1'b0;
      ecause_d = 2'b00;
      ecnt_d   = '0;
    end else if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // First sample after idle has no reference; just seed.
          last_d  = cur;
          state_d = TRACK;
        end
        TRACK: begin
          if (seq_err || comp_err) begin
            eflag_d  = 1'b1;
            ecause_d = {comp_err, seq_err};
            if (ecnt_q != '1) ecnt_d = ecnt_q + ERR_ONE;
            last_d   = cur;
            if (STOP_ON_ERROR) state_d = FAULT;
          end else if (!hold) begin
            last_d = cur;
            if (wrap) begin
              pulse_d = 1'b1;
              if (roll_q != '1) roll_d = roll_q + ROLL_ONE;
            end
          end
        end
        FAULT: state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= 4'h0;
      cv_q     <= 4'h0;
      pulse_q  <= 1'b0;
      roll_q   <= '0;
      eflag_q  <= 1'b0;
      ecause_q <= 2'b00;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cv_q     <= cv_d;
      pulse_q  <= pulse_d;
      roll_q   <= roll_d;
      eflag_q  <= eflag_d;
      ecause_q <= ecause_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign count_value    = cv_q;
  assign rollover_pulse = pulse_q;
  assign rollover_count = roll_q;
  assign error_flag     = eflag_q;
  assign error_cause    = ecause_q;
  assign error_count    = ecnt_q;
  assign state          = state_q;

endmodule
